// File: rtl/chopper_offtime_sequencer.sv
// Fixed-off-time chopper sequencer: drives a countdown timer through BLANK -> ON -> OFF phases
// from a synchronised overcurrent comparator, gating one microstepper phase bridge.
module chopper_offtime_sequencer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_overcurrent,
  input  logic [WIDTH-1:0]     i_blank_time,
  input  logic [WIDTH-1:0]     i_off_time,
  output logic                 o_timer_start_enable,
  output logic [WIDTH-1:0]     o_timer_start_time,
  input  logic                 i_timer_done,
  output logic                 o_bridge_on,
  output logic                 o_blanking,
  output logic                 o_off_active,
  output logic [CNT_WIDTH-1:0] o_chop_count
);

  typedef enum logic [1:0] {StIdle, StBlank, StOn, StOff} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [SYNC_STAGES-1:0] r_oc_sync;
  logic                   w_oc_s;
  logic                   w_pulse;
  logic                   w_sel_off;
  logic                   w_chop;
  logic [WIDTH-1:0]       w_load_raw;
  logic [WIDTH-1:0]       w_load_val;
  logic                   r_start_en;
  logic [WIDTH-1:0]       r_start_time;
  logic [CNT_WIDTH-1:0]   r_chop_count;

  // Overcurrent is asynchronous; only the last synchroniser stage is ever used.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oc_sync <= '0;
    end else begin
      r_oc_sync <= {r_oc_sync[SYNC_STAGES-2:0], i_overcurrent};
    end
  end

  assign w_oc_s = r_oc_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_next = r_state;
    w_pulse      = 1'b0;
    w_sel_off    = 1'b0;
    w_chop       = 1'b0;
    if (!i_enable) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_next = StBlank;
          w_pulse      = 1'b1;
        end
        StBlank: begin
          if (i_timer_done) w_state_next = StOn;
        end
        StOn: begin
          // Overcurrent beats a stale done; done is meaningless while ON.
          if (w_oc_s) begin
            w_state_next = StOff;
            w_pulse      = 1'b1;
            w_sel_off    = 1'b1;
            w_chop       = 1'b1;
          end
        end
        StOff: begin
          if (i_timer_done) begin
            w_state_next = StBlank;
            w_pulse      = 1'b1;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign w_load_raw = w_sel_off ? i_off_time : i_blank_time;
  assign w_load_val = (w_load_raw == '0) ? WIDTH'(1) : w_load_raw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_start_en   <= 1'b0;
      r_start_time <= '0;
      r_chop_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_start_en <= w_pulse;
      if (w_pulse) r_start_time <= w_load_val;
      if (w_chop && (r_chop_count != '1)) r_chop_count <= r_chop_count + 1'b1;
    end
  end

  assign o_timer_start_enable = r_start_en;
  assign o_timer_start_time   = r_start_time;
  assign o_bridge_on          = (r_state == StBlank) || (r_state == StOn);
  assign o_blanking           = (r_state == StBlank);
  assign o_off_active         = (r_state == StOff);
  assign o_chop_count         = r_chop_count;

endmodule
